// File: rtl/ysyx_24100006_axi_sram.sv
// AXI4 INCR-burst SRAM slave, 32-bit beats, independent read/write FSMs.
// Optional read latency: define YSYX_24100006_AXI_SRAM_DELAY_EN (uses RD_DELAY).
module ysyx_24100006_axi_sram #(
  parameter int MEM_WORDS  = 1024,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_DELAY   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic [7:0]            awlen_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic                  wlast_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            wstrb_i,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic [1:0]            bresp_o,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic [7:0]            arlen_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic                  rlast_o,
  output logic [31:0]           rdata_o,
  output logic [1:0]            rresp_o
);

  localparam int IW = $clog2(MEM_WORDS);

`ifdef YSYX_24100006_AXI_SRAM_DELAY_EN
  localparam int DW = $clog2(RD_DELAY + 1);
  typedef enum logic [1:0] {R_IDLE, R_BURST, R_WAIT} r_state_t;
  logic [DW-1:0] wait_cnt;
`else
  typedef enum logic [1:0] {R_IDLE, R_BURST} r_state_t;
`endif
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [MEM_WORDS];

  r_state_t r_q, r_d;
  w_state_t w_q, w_d;
  logic alive;

  logic [IW-1:0] r_idx, ld_idx, ar_idx;
  logic [7:0]    r_cnt, ld_cnt;
  logic [31:0]   rdata_q;
  logic          rlast_q;
  logic          r_load;

  logic [IW-1:0] w_idx;
  logic [7:0]    w_cnt;
  logic          w_err;
  logic [1:0]    bresp_q;

  logic ar_fire, r_fire, aw_fire, w_fire, b_fire;
  logic unused_ok;

  assign ar_idx  = araddr_i[IW+1:2];
  assign ar_fire = arvalid_i & arready_o;
  assign r_fire  = rvalid_o & rready_i;
  assign aw_fire = awvalid_i & awready_o;
  assign w_fire  = wvalid_i & wready_o;
  assign b_fire  = bvalid_o & bready_i;

  // alive keeps the ready outputs low until the first edge after reset
  assign arready_o = alive & (r_q == R_IDLE);
  assign rvalid_o  = (r_q == R_BURST);
  assign rdata_o   = rdata_q;
  assign rlast_o   = rlast_q;
  assign rresp_o   = 2'b00;

  assign awready_o = alive & (w_q == W_IDLE);
  assign wready_o  = (w_q == W_DATA);
  assign bvalid_o  = (w_q == W_RESP);
  assign bresp_o   = bresp_q;

`ifdef YSYX_24100006_AXI_SRAM_DELAY_EN
  assign unused_ok = ^{araddr_i[ADDR_WIDTH-1:IW+2], araddr_i[1:0],
                       awaddr_i[ADDR_WIDTH-1:IW+2], awaddr_i[1:0]};
`else
  assign unused_ok = ^{araddr_i[ADDR_WIDTH-1:IW+2], araddr_i[1:0],
                       awaddr_i[ADDR_WIDTH-1:IW+2], awaddr_i[1:0],
                       32'(RD_DELAY)};
`endif

  always_comb begin
    r_d    = r_q;
    r_load = 1'b0;
    ld_idx = r_idx;
    ld_cnt = r_cnt;
    unique case (r_q)
      R_IDLE: begin
        if (ar_fire) begin
`ifdef YSYX_24100006_AXI_SRAM_DELAY_EN
          r_d = R_WAIT;
`else
          r_d    = R_BURST;
          r_load = 1'b1;
          ld_idx = ar_idx;
          ld_cnt = arlen_i;
`endif
        end
      end
`ifdef YSYX_24100006_AXI_SRAM_DELAY_EN
      R_WAIT: begin
        if (wait_cnt == '0) begin
          r_d    = R_BURST;
          r_load = 1'b1;
        end
      end
`endif
      R_BURST: begin
        if (r_fire) begin
          if (rlast_q) r_d = R_IDLE;
          else r_load = 1'b1;
        end
      end
      default: r_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q     <= R_IDLE;
      alive   <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
`ifdef YSYX_24100006_AXI_SRAM_DELAY_EN
      wait_cnt <= '0;
`endif
    end else begin
      r_q   <= r_d;
      alive <= 1'b1;
      // ld_cnt is the number of beats still owed after the one being loaded
      if (r_load) begin
        rdata_q <= mem[ld_idx];
        r_idx   <= ld_idx + IW'(1);
        r_cnt   <= ld_cnt - 8'd1;
        rlast_q <= (ld_cnt == 8'd0);
      end else if (r_fire) begin
        rlast_q <= 1'b0;
      end
`ifdef YSYX_24100006_AXI_SRAM_DELAY_EN
      if (ar_fire) begin
        r_idx    <= ar_idx;
        r_cnt    <= arlen_i;
        wait_cnt <= DW'(RD_DELAY - 1);
      end else if (r_q == R_WAIT) begin
        wait_cnt <= wait_cnt - DW'(1);
      end
`endif
    end
  end

  always_comb begin
    w_d = w_q;
    unique case (w_q)
      W_IDLE: if (aw_fire) w_d = W_DATA;
      W_DATA: if (w_fire && w_cnt == 8'd0) w_d = W_RESP;
      W_RESP: if (b_fire) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q     <= W_IDLE;
      w_idx   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bresp_q <= 2'b00;
    end else begin
      w_q <= w_d;
      if (aw_fire) begin
        w_idx <= awaddr_i[IW+1:2];
        w_cnt <= awlen_i;
        w_err <= 1'b0;
      end else if (w_fire) begin
        w_idx <= w_idx + IW'(1);
        w_cnt <= w_cnt - 8'd1;
        if (w_cnt == 8'd0)
          bresp_q <= (wlast_i && !w_err) ? 2'b00 : 2'b10;
        else
          w_err <= w_err | wlast_i;
      end
    end
  end

  // storage is never reset; nonblocking write keeps same-cycle reads old
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < 4; b++)
        if (wstrb_i[b]) mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_axi_sram.sv
// Bench for ysyx_24100006_axi_sram: vector table, corner sequences,
// and randomized bursts against a word-array model.
module tb_ysyx_24100006_axi_sram;

  localparam int MW = 16;
`ifdef YSYX_24100006_AXI_SRAM_DELAY_EN
  localparam int EXP_LAT = 5;
`else
  localparam int EXP_LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  logic awvalid, awready, wvalid, wready, wlast;
  logic bvalid, bready, arvalid, arready;
  logic rvalid, rready, rlast;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [MW];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        wl [256];

  typedef struct {
    logic [31:0] addr;
    int          len;
    logic [31:0] base;
    logic [3:0]  strb;
    int          last_at;
    int          bdel;
    logic [1:0]  bresp;
    int          rmode;
  } vec_t;

  vec_t tbl [8];

  ysyx_24100006_axi_sram #(
    .MEM_WORDS(MW), .ADDR_WIDTH(32), .RD_DELAY(4)
  ) dut (
    .clk(clk), .reset(reset),
    .awvalid_i(awvalid), .awready_o(awready),
    .awaddr_i(awaddr), .awlen_i(awlen),
    .wvalid_i(wvalid), .wready_o(wready), .wlast_i(wlast),
    .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
    .arvalid_i(arvalid), .arready_o(arready),
    .araddr_i(araddr), .arlen_i(arlen),
    .rvalid_o(rvalid), .rready_i(rready), .rlast_o(rlast),
    .rdata_o(rdata), .rresp_o(rresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int w);
    case (w)
      0: return awready;
      1: return wready;
      2: return bvalid;
      default: return arready;
    endcase
  endfunction

  task automatic wait_ready(input int w);
    int n = 0;
    while (!rdy(w) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk($sformatf("timeout_%0d", w), 32'd0, 32'd1);
  endtask

  function automatic int widx(input logic [31:0] a, input int i);
    return ((int'(a >> 2) % MW) + i) % MW;
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len,
                          input int bdel, output logic [1:0] resp);
    int ix;
    awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    wait_ready(0);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = wl[i];
      wait_ready(1);
      @(negedge clk);
      ix = widx(addr, i);
      for (int b = 0; b < 4; b++)
        if (ws[i][b]) model[ix][8*b +: 8] = wd[i][8*b +: 8];
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b0;
    wait_ready(2);
    for (int k = 0; k < bdel; k++) begin
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      @(negedge clk);
    end
    bready = 1'b1;
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
    chk("widle_after_b", 32'({awready, bvalid}), 32'b10);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len,
                         input int mode, input int abort);
    int lat, beat, n;
    logic [31:0] exp [256];
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i <= len; i++) exp[i] = model[widx(addr, i)];
    araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    wait_ready(3);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("rd_latency", 32'(lat), 32'(EXP_LAT));
    beat = 0; n = 0;
    while (beat <= len && n < 300) begin
      if (beat == abort) begin
        rready = 1'b0;
        return;
      end
      case (mode)
        0: rready = 1'b1;
        1: rready = (n < 6) ? pat[n] : 1'b1;
        default: rready = 1'(($urandom & 1) == 1);
      endcase
      chk("rvalid", 32'(rvalid), 32'd1);
      chk($sformatf("rdata_b%0d", beat), rdata, exp[beat]);
      chk("rlast", 32'(rlast), 32'(beat == len));
      chk("rresp", 32'(rresp), 32'd0);
      chk("arready_busy", 32'(arready), 32'd0);
      if (rready) beat++;
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    if (n >= 300) chk("rd_timeout", 32'd0, 32'd1);
    chk("ridle_after", 32'({rvalid, arready}), 32'b01);
  endtask

  initial begin
    logic [1:0] resp;
    logic [1:0] eresp;
    logic [31:0] a;
    int len, bad;

    reset = 1'b0;
    {awvalid, wvalid, wlast, bready, arvalid, rready} = '0;
    awaddr = '0; araddr = '0; awlen = '0; arlen = '0;
    wdata = '0; wstrb = '0;

    tbl[0] = '{32'h10, 0, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 0};
    tbl[1] = '{32'h0, 3, 32'h1, 4'hF, 3, 0, 2'b00, 0};
    tbl[2] = '{32'h4, 0, 32'hAAAA5555, 4'h3, 0, 0, 2'b00, 0};
    tbl[3] = '{32'h20, 1, 32'h5A5A0000, 4'hF, 0, 3, 2'b10, 0};
    tbl[4] = '{32'h3C, 1, 32'h11110000, 4'hF, 1, 0, 2'b00, 0};
    tbl[5] = '{32'h28, 2, 32'h77000000, 4'hF, 9, 1, 2'b10, 2};
    tbl[6] = '{32'h30, 0, 32'hFFFFFFFF, 4'h0, 0, 0, 2'b00, 0};
    tbl[7] = '{32'hFFFF0042, 0, 32'hC0FFEE00, 4'hF, 0, 0, 2'b00, 2};

    repeat (2) @(negedge clk);
    chk("rst_readies", 32'({arready, awready, wready}), 32'd0);
    chk("rst_valids", 32'({rvalid, rlast, bvalid}), 32'd0);
    chk("rst_data", rdata, 32'd0);
    chk("rst_resp", 32'({bresp, rresp}), 32'd0);
    reset = 1'b1;
    #1 chk("rel_no_ready", 32'({arready, awready}), 32'd0);
    @(negedge clk);
    chk("rel_ready", 32'({arready, awready}), 32'b11);

    // known contents everywhere before anything reads
    for (int i = 0; i < MW; i++) begin
      wd[i] = 32'h0BAD0000 + 32'(i); ws[i] = 4'hF; wl[i] = (i == MW-1);
    end
    do_write(32'h0, MW-1, 0, resp);
    chk("fill_bresp", 32'(resp), 32'd0);
    do_read(32'h0, MW-1, 0, -1);

    // W beats offered before AW are not accepted
    wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF; wlast = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("w_before_aw", 32'(wready), 32'd0);
    end
    wvalid = 1'b0; wlast = 1'b0;

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i <= tbl[v].len; i++) begin
        wd[i] = tbl[v].base + 32'(i);
        ws[i] = tbl[v].strb;
        wl[i] = (i == tbl[v].last_at);
      end
      do_write(tbl[v].addr, tbl[v].len, tbl[v].bdel, resp);
      chk($sformatf("tbl%0d_bresp", v), 32'(resp), 32'(tbl[v].bresp));
      do_read(tbl[v].addr, tbl[v].len, tbl[v].rmode, -1);
      if (v == 2) do_read(32'h0, 3, 1, -1);
    end

    for (int it = 0; it < 25; it++) begin
      a = $urandom;
      len = $urandom_range(0, 5);
      bad = ($urandom_range(0, 3) == 0) ? 1 : 0;
      for (int i = 0; i <= len; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'($urandom_range(0, 15));
        wl[i] = bad ? 1'($urandom & 1) : (i == len);
      end
      eresp = wl[len] ? 2'b00 : 2'b10;
      for (int i = 0; i < len; i++) if (wl[i]) eresp = 2'b10;
      do_write(a, len, $urandom_range(0, 2), resp);
      chk("rnd_bresp", 32'(resp), 32'(eresp));
      do_read($urandom, $urandom_range(0, 7), 2, -1);
    end

    do_read(32'h8, 7, 0, 2);
    reset = 1'b0;
    #1 chk("rst_mid_rvalid", 32'({rvalid, rlast}), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    chk("rst_mid_ready", 32'({arready, awready}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_rel", 32'({arready, awready}), 32'b11);
    do_read(32'h0, MW-1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
